// File: rtl/data_mem_lsu_if.sv
// Request/response bundle between the core memory stage (master) and the LSU (slave).
// One transaction outstanding at a time; both directions use valid/ready.
interface data_mem_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_fault;

    modport master (
        output req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_fault
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_size, req_unsigned, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_fault
    );
endinterface

// File: rtl/data_mem_lsu.sv
// RV32 data memory with byte/half/word load-store front end, misalignment faults and
// a configurable response latency behind a single-outstanding valid/ready handshake.
module data_mem_lsu #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 1
) (
    input  logic               clk,
    input  logic               rst,
    data_mem_lsu_if.slave      bus
);
    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [1:0]  r_count;
    logic [1:0]  w_nextCount;

    logic [31:0] r_mem [DEPTH_WORDS] = '{default: '0};

    logic [31:0] r_pendData;
    logic        r_pendFault;
    logic [31:0] r_rspRdata;
    logic        r_rspFault;

    logic          w_accept;
    logic          w_enterResp;
    logic [AW-1:0] w_wordIdx;
    logic [1:0]    w_lane;
    logic          w_fault;
    logic [31:0]   w_readWord;
    logic [31:0]   w_shifted;
    logic [31:0]   w_loadData;
    logic [3:0]    w_byteEn;
    logic [31:0]   w_wdataLane;
    logic          w_doWrite;
    logic          w_unusedAddrBits;

    assign bus.req_ready = (r_state == S_IDLE) && !rst;
    assign bus.rsp_valid = (r_state == S_RESP);
    assign bus.rsp_rdata = r_rspRdata;
    assign bus.rsp_fault = r_rspFault;

    assign w_accept         = bus.req_valid && bus.req_ready;
    assign w_wordIdx        = bus.req_addr[AW+1:2];
    assign w_lane           = bus.req_addr[1:0];
    assign w_unusedAddrBits = ^bus.req_addr[31:AW+2];
    assign w_readWord       = r_mem[w_wordIdx];
    assign w_shifted        = w_readWord >> {w_lane, 3'b000};
    assign w_wdataLane      = bus.req_wdata << {w_lane, 3'b000};
    assign w_doWrite        = w_accept && bus.req_write && !w_fault;

    always_comb begin
        w_fault    = 1'b0;
        w_byteEn   = 4'b0000;
        w_loadData = 32'h0;
        case (bus.req_size)
            2'b00: begin
                w_byteEn   = 4'b0001 << w_lane;
                w_loadData = bus.req_unsigned ? {24'h0, w_shifted[7:0]}
                                              : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            2'b01: begin
                w_fault    = w_lane[0];
                w_byteEn   = 4'b0011 << w_lane;
                w_loadData = bus.req_unsigned ? {16'h0, w_shifted[15:0]}
                                              : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            2'b10: begin
                w_fault    = (w_lane != 2'b00);
                w_byteEn   = 4'b1111;
                w_loadData = w_readWord;
            end
            default: w_fault = 1'b1;
        endcase
        // Stores and faulting requests always answer with zero data.
        if (w_fault || bus.req_write) begin
            w_loadData = 32'h0;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_nextState = S_RESP;
                        w_nextCount = 2'd0;
                    end else begin
                        w_nextState = S_WAIT;
                        w_nextCount = 2'(LATENCY - 1);
                    end
                end
            end
            S_WAIT: begin
                w_nextCount = r_count - 2'd1;
                if (r_count <= 2'd1) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    assign w_enterResp = (w_nextState == S_RESP) && (r_state != S_RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_count     <= 2'd0;
            r_pendData  <= 32'h0;
            r_pendFault <= 1'b0;
            r_rspRdata  <= 32'h0;
            r_rspFault  <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_accept) begin
                r_pendData  <= w_loadData;
                r_pendFault <= w_fault;
            end
            // Response registers only move on entry to RESP, so they stay stable until consumed.
            if (w_enterResp) begin
                r_rspRdata <= (r_state == S_WAIT) ? r_pendData  : w_loadData;
                r_rspFault <= (r_state == S_WAIT) ? r_pendFault : w_fault;
            end
        end
    end

    // RAM is never reset, so an accepted store survives a later reset.
    always_ff @(posedge clk) begin
        if (w_doWrite) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_mem[w_wordIdx][8*b +: 8] <= w_wdataLane[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench for data_mem_lsu with a 1024-word RAM (so 0x1000 wraps to word 0)
// and LATENCY=3 so the wait state and back-pressure paths are exercised.
module tb_data_mem_lsu;
    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    data_mem_lsu_if lsuBus();

    data_mem_lsu #(
        .DEPTH_WORDS(1024),
        .LATENCY    (LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(lsuBus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // One full transaction; optionally holds rsp_ready low and presents a junk store meanwhile.
    task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input logic expFault, input int holdCycles);
        int n;
        lsuBus.req_valid    = 1'b1;
        lsuBus.req_write    = wr;
        lsuBus.req_addr     = addr;
        lsuBus.req_size     = size;
        lsuBus.req_unsigned = uns;
        lsuBus.req_wdata    = wdata;
        lsuBus.rsp_ready    = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".req_ready"}, 32'(lsuBus.req_ready), 32'd1);
        @(posedge clk);
        #1;
        lsuBus.req_valid = 1'b0;
        n = 0;
        while (!lsuBus.rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({tag, ".latency"}, 32'(n), 32'(LAT - 1));
        if (!lsuBus.rsp_valid) return;
        checkOutput({tag, ".rdata"}, lsuBus.rsp_rdata, expRdata);
        checkOutput({tag, ".fault"}, 32'(lsuBus.rsp_fault), 32'(expFault));
        if (holdCycles > 0) begin
            lsuBus.req_valid = 1'b1;
            lsuBus.req_write = 1'b1;
            lsuBus.req_addr  = 32'h0000_0100;
            lsuBus.req_size  = 2'b10;
            lsuBus.req_wdata = 32'h0BAD_F00D;
            for (int i = 0; i < holdCycles; i++) begin
                @(posedge clk);
                #1;
                checkOutput({tag, ".holdValid"}, 32'(lsuBus.rsp_valid), 32'd1);
                checkOutput({tag, ".holdRdata"}, lsuBus.rsp_rdata, expRdata);
                checkOutput({tag, ".holdReady"}, 32'(lsuBus.req_ready), 32'd0);
            end
            lsuBus.req_valid = 1'b0;
        end
        lsuBus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        lsuBus.rsp_ready = 1'b0;
        checkOutput({tag, ".consumed"}, 32'(lsuBus.rsp_valid), 32'd0);
        checkOutput({tag, ".readyBack"}, 32'(lsuBus.req_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        lsuBus.req_valid    = 1'b0;
        lsuBus.req_write    = 1'b0;
        lsuBus.req_addr     = 32'h0;
        lsuBus.req_size     = 2'b10;
        lsuBus.req_unsigned = 1'b0;
        lsuBus.req_wdata    = 32'h0;
        lsuBus.rsp_ready    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset.req_ready", 32'(lsuBus.req_ready), 32'd0);
        checkOutput("reset.rsp_valid", 32'(lsuBus.rsp_valid), 32'd0);
        checkOutput("reset.rsp_rdata", lsuBus.rsp_rdata, 32'h0);
        checkOutput("reset.rsp_fault", 32'(lsuBus.rsp_fault), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("release.req_ready", 32'(lsuBus.req_ready), 32'd1);

        applyStimulus("lwTop",  1'b0, 32'h0000_0FFC, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        applyStimulus("lwWrap", 1'b0, 32'h0000_1000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 0);

        applyStimulus("swBeef", 1'b1, 32'h8542_3918, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 0);
        applyStimulus("lwBeef", 1'b0, 32'h8542_3918, 2'b10, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        applyStimulus("lwAlias", 1'b0, 32'h0000_0918, 2'b10, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 0);
        applyStimulus("lbS3",   1'b0, 32'h8542_391B, 2'b00, 1'b0, 32'h0, 32'hFFFF_FFDE, 1'b0, 0);
        applyStimulus("lbU3",   1'b0, 32'h8542_391B, 2'b00, 1'b1, 32'h0, 32'h0000_00DE, 1'b0, 0);
        applyStimulus("lhS0",   1'b0, 32'h8542_3918, 2'b01, 1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0, 0);
        applyStimulus("lhU2",   1'b0, 32'h8542_391A, 2'b01, 1'b1, 32'h0, 32'h0000_DEAD, 1'b0, 0);

        applyStimulus("swBase", 1'b1, 32'h0000_0100, 2'b10, 1'b0, 32'h1122_3344, 32'h0, 1'b0, 0);
        applyStimulus("sbLane1", 1'b1, 32'h0000_0101, 2'b00, 1'b0, 32'hFFFF_FF5A, 32'h0, 1'b0, 0);
        applyStimulus("lwAfterSb", 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 32'h1122_5A44, 1'b0, 0);
        applyStimulus("shLane2", 1'b1, 32'h0000_0102, 2'b01, 1'b0, 32'hFFFF_8001, 32'h0, 1'b0, 0);
        applyStimulus("lwAfterSh", 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 32'h8001_5A44, 1'b0, 0);
        applyStimulus("lbS3b",  1'b0, 32'h0000_0103, 2'b00, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0, 0);

        applyStimulus("lwMis",   1'b0, 32'h0000_0002, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("lwMis2",  1'b0, 32'h0000_0102, 2'b10, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("shMis",   1'b1, 32'h0000_0001, 2'b01, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1, 0);
        applyStimulus("shMis2",  1'b1, 32'h0000_0101, 2'b01, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1, 0);
        applyStimulus("ldRsvd",  1'b0, 32'h0000_0100, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("stRsvd",  1'b1, 32'h0000_0100, 2'b11, 1'b0, 32'h0, 32'h0, 1'b1, 0);
        applyStimulus("rbWord0", 1'b0, 32'h0000_0000, 2'b10, 1'b0, 32'h0, 32'h0, 1'b0, 0);
        applyStimulus("rbWord1", 1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 32'h8001_5A44, 1'b0, 0);

        applyStimulus("hold",    1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 32'h8001_5A44, 1'b0, 5);
        applyStimulus("rbHold",  1'b0, 32'h0000_0100, 2'b10, 1'b0, 32'h0, 32'h8001_5A44, 1'b0, 0);

        lsuBus.req_valid = 1'b1;
        lsuBus.req_write = 1'b1;
        lsuBus.req_addr  = 32'h0000_0200;
        lsuBus.req_size  = 2'b10;
        lsuBus.req_wdata = 32'hCAFE_F00D;
        @(posedge clk);
        #1;
        lsuBus.req_valid = 1'b0;
        checkOutput("midRst.inWait", 32'(lsuBus.req_ready), 32'd0);
        rst = 1'b1;
        #1;
        checkOutput("midRst.valid", 32'(lsuBus.rsp_valid), 32'd0);
        checkOutput("midRst.ready", 32'(lsuBus.req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("midRst.readyAfter", 32'(lsuBus.req_ready), 32'd1);
        repeat (LAT) @(posedge clk);
        #1;
        checkOutput("midRst.dropped", 32'(lsuBus.rsp_valid), 32'd0);
        applyStimulus("midRst.readBack", 1'b0, 32'h0000_0200, 2'b10, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
